// File: rtl/store_buffer.sv
// Post-commit store queue: checks store alignment, lines up byte lanes on enqueue and
// drains entries in order over a req/addr_ok/data_ok bus, one transaction at a time.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [1:0]    st_size,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  output logic          st_ale,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic          sb_empty,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, WAIT_DATA = 1'b1} state_t;
  state_t state, state_nx;

  logic [AW-1:0] addr_q [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic [3:0]    strb_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;

  logic          aligned, enq, pop;
  logic [3:0]    enq_strb;
  logic [DW-1:0] enq_data;
  logic [1:0]    unused_ld;

  assign unused_ld = ld_addr[1:0];

  always_comb begin
    aligned = 1'b0;
    case (st_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~st_addr[0];
      2'd2:    aligned = (st_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    enq_strb = 4'b1111;
    enq_data = st_data;
    case (st_size)
      2'd0: begin
        enq_strb = 4'b0001 << st_addr[1:0];
        enq_data = {24'b0, st_data[7:0]} << {st_addr[1:0], 3'b000};
      end
      2'd1: begin
        enq_strb = st_addr[1] ? 4'b1100 : 4'b0011;
        enq_data = st_addr[1] ? {st_data[15:0], 16'b0} : {16'b0, st_data[15:0]};
      end
      default: begin
        enq_strb = 4'b1111;
        enq_data = st_data;
      end
    endcase
  end

  assign st_ready = (count != (PW+1)'(DEPTH));
  assign st_ale   = st_valid && !aligned;
  assign enq      = st_valid && st_ready && aligned;
  assign data_req = (count != '0) && (state == IDLE);
  assign data_wr  = data_req;
  assign sb_empty = (count == '0) && (state == IDLE);

  assign data_addr  = addr_q[rptr];
  assign data_size  = size_q[rptr];
  assign data_wstrb = strb_q[rptr];
  assign data_wdata = data_q[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (data_req && data_addr_ok) begin
          if (data_data_ok) pop = 1'b1;
          else              state_nx = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_data_ok) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        size_q[i] <= '0;
        strb_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[wptr] <= st_addr;
        size_q[wptr] <= st_size;
        strb_q[wptr] <= enq_strb;
        data_q[wptr] <= enq_data;
        wptr         <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [PW-1:0] ofs;
    ld_hit = 1'b0;
    ofs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ofs = PW'(i) - rptr;
      if (({1'b0, ofs} < count) && (addr_q[i][AW-1:2] == ld_addr[AW-1:2]))
        ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected bus writes are queued at enqueue time
// and compared against the head-entry bus outputs when the bench grants each transaction.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [31:0] st_data;
  logic        st_ready, st_ale;
  logic [31:0] ld_addr;
  logic        ld_hit, sb_empty;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
    .st_ready(st_ready), .st_ale(st_ale),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .sb_empty(sb_empty),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_aligned(input logic [31:0] a, input logic [1:0] s);
    int nb;
    if (s == 2'd3) return 1'b0;
    nb = 1 << s;
    return (a % nb) == 0;
  endfunction

  // Lane-by-lane placement of the LSB-justified bytes.
  function automatic exp_t model_entry(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    exp_t e;
    int off, nb;
    off = a[1:0];
    nb  = 1 << s;
    e.addr = a;
    e.size = s;
    e.strb = '0;
    e.data = '0;
    for (int l = 0; l < 4; l++) begin
      if (l >= off && l < off + nb) begin
        e.strb[l]         = 1'b1;
        e.data[8*l +: 8]  = d[8*(l-off) +: 8];
      end
    end
    return e;
  endfunction

  function automatic logic model_hit(input logic [31:0] la);
    foreach (exp_q[i])
      if (exp_q[i].addr[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic ok, rdy;
    st_valid = 1'b1; st_addr = a; st_size = s; st_data = d;
    #1;
    ok  = model_aligned(a, s);
    rdy = (exp_q.size() != DEPTH);
    chk("st_ale", st_ale, !ok);
    chk("st_ready", st_ready, rdy);
    if (ok && rdy) exp_q.push_back(model_entry(a, s, d));
    cycle();
    st_valid = 1'b0;
  endtask

  task automatic wait_req(output logic got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (data_req) begin got = 1'b1; break; end
      cycle();
    end
    if (!got) chk("req_timeout", 0, 1);
  endtask

  task automatic head_check();
    if (exp_q.size() == 0) begin
      chk("sb_underflow", data_req, 0);
      return;
    end
    chk("data_addr", data_addr, exp_q[0].addr);
    chk("data_size", data_size, exp_q[0].size);
    chk("data_wstrb", data_wstrb, exp_q[0].strb);
    chk("data_wdata", data_wdata, exp_q[0].data);
    chk("data_wr", data_wr, 1);
  endtask

  // gap = cycles between the addr_ok cycle and the data_ok cycle (0 = same cycle).
  task automatic drain_one(input int gap);
    logic got;
    wait_req(got);
    if (!got) return;
    head_check();
    data_addr_ok = 1'b1;
    data_data_ok = (gap == 0);
    cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (gap > 0) begin
      for (int n = 0; n < gap - 1; n++) begin
        chk("wait_noreq", data_req, 0);
        cycle();
      end
      data_data_ok = 1'b1;
      cycle();
      data_data_ok = 1'b0;
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; st_valid = 0; st_addr = 0; st_size = 0; st_data = 0;
    ld_addr = 0; data_addr_ok = 0; data_data_ok = 0;
    #12;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_st_ale", st_ale, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_sb_empty", sb_empty, 1);
    chk("rst_data_req", data_req, 0);
    chk("rst_data_bus", {data_wstrb, data_size, data_wr}, 0);
    chk("rst_data_word", {data_addr, data_wdata}, 0);
    rst = 1'b0;
    cycle();

    // byte store: request in the cycle right after the enqueue edge
    store(32'h1000_0003, 2'd0, 32'h0000_00AB);
    chk("byte_req", data_req, 1);
    chk("byte_wstrb_abs", data_wstrb, 4'b1000);
    chk("byte_wdata_abs", data_wdata, 32'hAB00_0000);
    drain_one(2);
    chk("byte_empty", sb_empty, 1);

    // half store plus two rejected stores
    store(32'h0000_2002, 2'd1, 32'h0000_1234);
    chk("half_wdata_abs", data_wdata, 32'h1234_0000);
    store(32'h0000_2001, 2'd1, 32'h0000_5678);
    store(32'h0000_2000, 2'd3, 32'h0000_9999);
    drain_one(1);
    chk("half_empty", sb_empty, 1);

    // fill to full with the bus stalled
    for (int i = 0; i < DEPTH; i++)
      store(32'h0000_4000 + 32'(4*i), 2'd2, 32'hC0DE_0000 + 32'(i));
    chk("full_ready", st_ready, 0);
    store(32'h0000_5000, 2'd2, 32'hDEAD_BEEF);
    // pop and enqueue in the full cycle: store is still refused
    st_valid = 1; st_addr = 32'h0000_5004; st_size = 2'd2; st_data = 32'h1111_2222;
    data_addr_ok = 1; data_data_ok = 1;
    #1;
    chk("fullpop_ready", st_ready, 0);
    head_check();
    cycle();
    st_valid = 0; data_addr_ok = 0; data_data_ok = 0;
    void'(exp_q.pop_front());
    chk("after_fullpop_ready", st_ready, 1);
    for (int i = 1; i < DEPTH; i++) drain_one(0);
    chk("wrap_empty", sb_empty, 1);

    // load hazard
    store(32'h0000_3004, 2'd2, 32'h0BAD_F00D);
    ld_addr = 32'h0000_3006; #1;
    chk("ld_hit_same", ld_hit, model_hit(ld_addr));
    ld_addr = 32'h0000_3008; #1;
    chk("ld_hit_other", ld_hit, model_hit(ld_addr));
    drain_one(1);
    ld_addr = 32'h0000_3006; #1;
    chk("ld_hit_popped", ld_hit, 0);

    // simultaneous enqueue and pop at count 2
    store(32'h0000_6000, 2'd2, 32'hAAAA_0001);
    store(32'h0000_6004, 2'd0, 32'h0000_00BB);
    st_valid = 1; st_addr = 32'h0000_6008; st_size = 2'd1; st_data = 32'h0000_CCDD;
    data_addr_ok = 1; data_data_ok = 1;
    #1;
    chk("simul_ready", st_ready, 1);
    head_check();
    cycle();
    st_valid = 0; data_addr_ok = 0; data_data_ok = 0;
    void'(exp_q.pop_front());
    exp_q.push_back(model_entry(32'h0000_6008, 2'd1, 32'h0000_CCDD));
    chk("simul_next_addr", data_addr, 32'h0000_6004);
    chk("simul_hit_new", ld_hit, 0);
    ld_addr = 32'h0000_600A; #1;
    chk("simul_hit_model", ld_hit, model_hit(ld_addr));
    drain_one(0);
    drain_one(0);
    chk("simul_empty", sb_empty, 1);

    // reset while waiting for data_ok with three entries queued
    store(32'h0000_7000, 2'd2, 32'h7000_0000);
    store(32'h0000_7004, 2'd2, 32'h7000_0004);
    store(32'h0000_7008, 2'd2, 32'h7000_0008);
    data_addr_ok = 1; cycle(); data_addr_ok = 0;
    chk("wait_state_req", data_req, 0);
    chk("wait_state_busy", sb_empty, 0);
    rst = 1'b1; #1;
    chk("midrst_req", data_req, 0);
    chk("midrst_empty", sb_empty, 1);
    chk("midrst_ready", st_ready, 1);
    exp_q.delete();
    cycle();
    rst = 1'b0;
    cycle();
    store(32'h0000_8001, 2'd0, 32'h0000_0042);
    drain_one(1);
    chk("post_rst_empty", sb_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
